// File: rtl/pixel_word_packer_pkg.sv
// Shared constants, FSM state type and byte-placement helper for the pixel word packer.
package pkt_pkg;

  localparam int COLOR_SIZE      = 8;
  localparam int PIXEL_SIZE      = 24;
  localparam int BYTES_PER_PIXEL = 3;
  localparam int BYTES_PER_WORD  = 4;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Positions a pixel at byte offset off inside a zero 64-bit buffer image.
  function automatic logic [63:0] place_pixel(input logic [PIXEL_SIZE-1:0] pix,
                                              input logic [CNT_W-1:0] off);
    return {40'd0, pix} << {off, 3'b000};
  endfunction

endpackage

// File: rtl/pixel_word_packer_byte_shift_buf.sv
// 64-bit LSB-first byte buffer: pops up to 4 bytes, then appends 3 bytes at the new fill level.
module byte_shift_buf
  import pkt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [PIXEL_SIZE-1:0] pix_i,
  output logic [31:0]           word_o,
  output logic [CNT_W-1:0]      cnt_o
);

  logic [63:0]      buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      buf_pop_s;
  logic [CNT_W-1:0] cnt_pop_s;

  // Bytes above cnt are always zero, so a short final word comes out zero-padded.
  always_comb begin
    buf_pop_s = buf_q;
    cnt_pop_s = cnt_q;
    if (pop_i) begin
      buf_pop_s = {32'd0, buf_q[63:32]};
      cnt_pop_s = (cnt_q > 4'(BYTES_PER_WORD)) ? (cnt_q - 4'(BYTES_PER_WORD)) : 4'd0;
    end else begin
      buf_pop_s = buf_q;
      cnt_pop_s = cnt_q;
    end
    if (push_i) begin
      buf_d = buf_pop_s | place_pixel(pix_i, cnt_pop_s);
      cnt_d = cnt_pop_s + 4'(BYTES_PER_PIXEL);
    end else begin
      buf_d = buf_pop_s;
      cnt_d = cnt_pop_s;
    end
  end

  // Buffer contents and fill level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= 64'd0;
      cnt_q <= 4'd0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o = buf_q[31:0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pixel_word_packer.sv
// Packs 24-bit pixels densely into 32-bit slave-port words with backpressure and frame flush.
module pixel_word_packer
  import pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WCNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [COLOR_SIZE-1:0] cfg_proc_val,
  input  logic                  pix_valid,
  input  logic [PIXEL_SIZE-1:0] pix_data,
  input  logic                  pix_last,
  output logic                  pix_rdy,
  output logic [1:0]            slv_mode,
  output logic [COLOR_SIZE-1:0] slv_proc_val,
  output logic [DATA_WIDTH-1:0] slv_data,
  output logic                  slv_data_valid,
  input  logic                  slv_rdy,
  output logic                  slv_data_last,
  output logic                  frame_done,
  output logic [WCNT_W-1:0]     word_cnt
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("pixel_word_packer supports only DATA_WIDTH=32");
  end

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [COLOR_SIZE-1:0] pv_q, pv_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0]      cnt_s;
  logic [31:0]           word_s;
  logic                  pix_rdy_s, valid_s, last_s, done_s;
  logic                  pix_xfer_s, word_xfer_s, start_ok_s;

  assign pix_xfer_s  = pix_valid & pix_rdy_s;
  assign word_xfer_s = valid_s & slv_rdy;
  assign start_ok_s  = start & (state_q == IDLE);

  byte_shift_buf u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (pix_xfer_s),
    .pop_i  (word_xfer_s),
    .pix_i  (pix_data),
    .word_o (word_s),
    .cnt_o  (cnt_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PACK; else state_d = IDLE;
      PACK:    if (pix_xfer_s && pix_last) state_d = FLUSH; else state_d = PACK;
      FLUSH: begin
        if (cnt_s == 4'd0) state_d = DONE;
        else if (word_xfer_s && (cnt_s <= 4'd4)) state_d = DONE;
        else state_d = FLUSH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state and fill level only; at cnt==6 a
  // full-rate stream stalls one cycle because slv_rdy is not allowed to reach pix_rdy.
  always_comb begin
    pix_rdy_s = 1'b0;
    valid_s   = 1'b0;
    last_s    = 1'b0;
    done_s    = 1'b0;
    case (state_q)
      IDLE: begin
        pix_rdy_s = 1'b0;
      end
      PACK: begin
        pix_rdy_s = (cnt_s <= 4'd5);
        valid_s   = (cnt_s >= 4'd4);
      end
      FLUSH: begin
        valid_s = (cnt_s != 4'd0);
        last_s  = (cnt_s != 4'd0) && (cnt_s <= 4'd4);
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        pix_rdy_s = 1'b0;
      end
    endcase
  end

  // Frame configuration latch and word counter next-state.
  always_comb begin
    mode_d = mode_q;
    pv_d   = pv_q;
    wcnt_d = wcnt_q;
    if (start_ok_s) begin
      mode_d = cfg_mode;
      pv_d   = cfg_proc_val;
      wcnt_d = {WCNT_W{1'b0}};
    end else if (word_xfer_s) begin
      wcnt_d = wcnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Frame configuration and word counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= 2'd0;
      pv_q   <= {COLOR_SIZE{1'b0}};
      wcnt_q <= {WCNT_W{1'b0}};
    end else begin
      mode_q <= mode_d;
      pv_q   <= pv_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign pix_rdy        = pix_rdy_s;
  assign slv_mode       = mode_q;
  assign slv_proc_val   = pv_q;
  assign slv_data       = word_s[DATA_WIDTH-1:0];
  assign slv_data_valid = valid_s;
  assign slv_data_last  = last_s;
  assign frame_done     = done_s;
  assign word_cnt       = wcnt_q;

endmodule
